// File: rtl/rr_arbiter_pkg.sv
// Shared definitions for the round-robin arbiter: FSM states, default
// parameter values and the index-width helper.
package rr_arbiter_pkg;

  // Arbiter FSM: IDLE has no grant outstanding, BUSY holds one grant.
  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  localparam int DEFAULT_N        = 8;
  localparam int DEFAULT_MAX_HOLD = 16;

  // Width of a binary requester index; never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage : rr_arbiter_pkg

// File: rtl/lowest_one.sv
// Isolates the lowest set bit of an N-bit vector. An LSB-first prefix OR
// marks every position at or above the first one; clearing the positions
// whose lower neighbour is also marked leaves just that first one.
module lowest_one #(
  parameter int N = 8
) (
  input  logic [N-1:0] vec_i,
  output logic [N-1:0] low_o
);

  logic [N-1:0] prefix_or;

  // LSB-first prefix OR, built with a running accumulator so the vector
  // never reads its own bits.
  always_comb begin
    logic run;
    run       = 1'b0;
    prefix_or = '0;
    for (int i = 0; i < N; i++) begin
      run          = run | vec_i[i];
      prefix_or[i] = run;
    end
  end

  assign low_o = prefix_or & ~(prefix_or << 1);

endmodule : lowest_one

// File: rtl/rr_arbiter.sv
// Round-robin arbiter with a hold-time limit. One requester at a time owns
// the shared resource until it signals done or overstays MAX_HOLD cycles;
// on release the search pointer moves just past the released holder and a
// waiting requester is granted on the same edge.
module rr_arbiter
  import rr_arbiter_pkg::*;
#(
  parameter int N        = DEFAULT_N,
  parameter int MAX_HOLD = DEFAULT_MAX_HOLD
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N-1:0]         req,
  input  logic                 done,
  output logic [N-1:0]         gnt,
  output logic                 gnt_valid,
  output logic [$clog2(N)-1:0] gnt_idx,
  output logic                 timeout
);

  localparam int IW = idx_width(N);
  localparam int HW = $clog2(MAX_HOLD + 1);

  localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(N - 1);

  // Registered state
  state_e        state_q,     state_d;
  logic [N-1:0]  gnt_q,       gnt_d;
  logic          gnt_valid_q, gnt_valid_d;
  logic [IW-1:0] gnt_idx_q,   gnt_idx_d;
  logic          timeout_q,   timeout_d;
  logic [IW-1:0] ptr_q,       ptr_d;
  logic [HW-1:0] hold_cnt_q,  hold_cnt_d;

  // Arbitration datapath
  logic          busy;
  logic          hold_limit;
  logic          release_evt;
  logic          forced_release;
  logic [IW-1:0] ptr_next;
  logic [IW-1:0] arb_ptr;
  logic [N-1:0]  cand;
  logic [N-1:0]  ptr_mask;
  logic [N-1:0]  cand_masked;
  logic [N-1:0]  low_masked;
  logic [N-1:0]  low_all;
  logic [N-1:0]  sel;
  logic [IW-1:0] sel_idx;

  assign busy       = (state_q == BUSY);
  assign hold_limit = (hold_cnt_q == HOLD_LAST);

  // done takes priority, so a release that coincides with the hold limit
  // is an ordinary release and raises no timeout.
  assign release_evt    = busy && (done || hold_limit);
  assign forced_release = busy && !done && hold_limit;

  // Pointer position just past the current holder, wrapping at N.
  assign ptr_next = (gnt_idx_q == IDX_LAST) ? '0 : gnt_idx_q + IW'(1);

  // Candidate set and search start: fresh requests from IDLE, or everyone
  // except the outgoing holder when re-arbitrating on a release.
  // NOTE: every combinational output gets a default before any branch so
  // no path leaves it unassigned, which would infer a latch.
  always_comb begin
    cand     = busy ? (req & ~gnt_q) : req;
    arb_ptr  = busy ? ptr_next : ptr_q;
    ptr_mask = '0;
    for (int i = 0; i < N; i++) begin
      ptr_mask[i] = (IW'(i) >= arb_ptr);
    end
    cand_masked = cand & ptr_mask;
  end

  lowest_one #(.N(N)) u_low_masked (
    .vec_i (cand_masked),
    .low_o (low_masked)
  );

  lowest_one #(.N(N)) u_low_all (
    .vec_i (cand),
    .low_o (low_all)
  );

  // Winner: first candidate at or above the pointer, else wrap to the
  // lowest candidate; its index is the OR of the positions of set bits.
  always_comb begin
    sel     = (|cand_masked) ? low_masked : low_all;
    sel_idx = '0;
    for (int i = 0; i < N; i++) begin
      if (sel[i]) begin
        sel_idx = sel_idx | IW'(i);
      end
    end
  end

  // Next-state and next-output logic for the IDLE/BUSY controller.
  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    gnt_valid_d = gnt_valid_q;
    gnt_idx_d   = gnt_idx_q;
    ptr_d       = ptr_q;
    hold_cnt_d  = hold_cnt_q;
    timeout_d   = 1'b0;

    unique case (state_q)
      IDLE: begin
        // done with no holder is meaningless and ignored here.
        if (|req) begin
          state_d     = BUSY;
          gnt_d       = sel;
          gnt_valid_d = 1'b1;
          gnt_idx_d   = sel_idx;
          hold_cnt_d  = '0;
        end
      end

      BUSY: begin
        if (release_evt) begin
          ptr_d     = ptr_next;
          timeout_d = forced_release;
          if (|cand) begin
            // Back-to-back hand-over, no idle cycle.
            gnt_d       = sel;
            gnt_valid_d = 1'b1;
            gnt_idx_d   = sel_idx;
            hold_cnt_d  = '0;
          end else begin
            state_d     = IDLE;
            gnt_d       = '0;
            gnt_valid_d = 1'b0;
            gnt_idx_d   = '0;
            hold_cnt_d  = '0;
          end
        end else begin
          // Grant is frozen while held, whatever req does.
          hold_cnt_d = hold_cnt_q + HW'(1);
        end
      end

      default: begin
        state_d     = IDLE;
        gnt_d       = '0;
        gnt_valid_d = 1'b0;
        gnt_idx_d   = '0;
        hold_cnt_d  = '0;
      end
    endcase
  end

  // State and output registers; reset drops any grant immediately.
  // NOTE: clocked state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      gnt_q       <= '0;
      gnt_valid_q <= 1'b0;
      gnt_idx_q   <= '0;
      timeout_q   <= 1'b0;
      ptr_q       <= '0;
      hold_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      gnt_valid_q <= gnt_valid_d;
      gnt_idx_q   <= gnt_idx_d;
      timeout_q   <= timeout_d;
      ptr_q       <= ptr_d;
      hold_cnt_q  <= hold_cnt_d;
    end
  end

  assign gnt       = gnt_q;
  assign gnt_valid = gnt_valid_q;
  assign gnt_idx   = gnt_idx_q;
  assign timeout   = timeout_q;

endmodule : rr_arbiter

// File: tb/tb_rr_arbiter.sv
// Self-checking bench for rr_arbiter with N=4, MAX_HOLD=4. Vectors are
// {req, done} plus the grant and timeout expected after the next edge;
// expectations go into a scoreboard queue when driven and are popped and
// compared once the edge has produced the DUT output.
module tb_rr_arbiter;

  localparam int N        = 4;
  localparam int MAX_HOLD = 4;

  logic         clk  = 1'b0;
  logic         rst  = 1'b1;
  logic [N-1:0] req  = '0;
  logic         done = 1'b0;
  logic [N-1:0] gnt;
  logic         gnt_valid;
  logic [1:0]   gnt_idx;
  logic         timeout;

  always #5 clk = ~clk;

  rr_arbiter #(
    .N        (N),
    .MAX_HOLD (MAX_HOLD)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .done      (done),
    .gnt       (gnt),
    .gnt_valid (gnt_valid),
    .gnt_idx   (gnt_idx),
    .timeout   (timeout)
  );

  typedef struct {
    logic [3:0] req;
    logic       done;
    logic [3:0] gnt;
    logic       to;
  } vec_t;

  typedef struct {
    string      name;
    logic [3:0] gnt;
    logic       valid;
    logic [1:0] idx;
    logic       to;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req_val);
    total++;
    if (act !== req_val) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, req_val);
    end
  endtask

  function automatic logic [1:0] idx_of(input logic [3:0] g);
    logic [1:0] r;
    r = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (g[i]) r = 2'(i);
    end
    return r;
  endfunction

  function automatic void add(input logic [3:0] r, input logic d, input logic [3:0] g, input logic t);
    vec_t v;
    v.req  = r;
    v.done = d;
    v.gnt  = g;
    v.to   = t;
    vecs.push_back(v);
  endfunction

  task automatic compare_out();
    exp_t e;
    e = sb.pop_front();
    check({e.name, " gnt"},       32'(gnt),       32'(e.gnt));
    check({e.name, " gnt_valid"}, 32'(gnt_valid), 32'(e.valid));
    check({e.name, " gnt_idx"},   32'(gnt_idx),   32'(e.idx));
    check({e.name, " timeout"},   32'(timeout),   32'(e.to));
  endtask

  task automatic step(input string name, input logic [3:0] r, input logic d,
                      input logic [3:0] eg, input logic eto);
    exp_t e;
    @(negedge clk);
    req     = r;
    done    = d;
    e.name  = name;
    e.gnt   = eg;
    e.valid = |eg;
    e.idx   = idx_of(eg);
    e.to    = eto;
    sb.push_back(e);
    @(posedge clk);
    #1;
    compare_out();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Basic grant then hand-over to the next requester above the holder.
    add(4'b1010, 1'b0, 4'b0010, 1'b0);
    add(4'b1010, 1'b1, 4'b1000, 1'b0);
    add(4'b0000, 1'b1, 4'b0000, 1'b0);
    // All requesting with done every cycle: 0,1,2,3,0 without gaps.
    add(4'b1111, 1'b0, 4'b0001, 1'b0);
    add(4'b1111, 1'b1, 4'b0010, 1'b0);
    add(4'b1111, 1'b1, 4'b0100, 1'b0);
    add(4'b1111, 1'b1, 4'b1000, 1'b0);
    add(4'b1111, 1'b1, 4'b0001, 1'b0);
    // Grant to 3, then wrap to 0; then a masked-empty wrap from ptr=2.
    add(4'b1000, 1'b1, 4'b1000, 1'b0);
    add(4'b0011, 1'b1, 4'b0001, 1'b0);
    add(4'b0011, 1'b1, 4'b0010, 1'b0);
    add(4'b0001, 1'b1, 4'b0001, 1'b0);
    add(4'b0000, 1'b1, 4'b0000, 1'b0);
    // done while idle changes nothing.
    add(4'b0000, 1'b1, 4'b0000, 1'b0);
    // Hold limit: four BUSY cycles then forced release with timeout.
    add(4'b0101, 1'b0, 4'b0100, 1'b0);
    add(4'b0101, 1'b0, 4'b0100, 1'b0);
    add(4'b0101, 1'b0, 4'b0100, 1'b0);
    add(4'b0101, 1'b0, 4'b0100, 1'b0);
    add(4'b0101, 1'b0, 4'b0001, 1'b1);
    add(4'b0001, 1'b0, 4'b0001, 1'b0);
    // done on the same edge as the hold limit: normal release.
    add(4'b0001, 1'b0, 4'b0001, 1'b0);
    add(4'b0001, 1'b0, 4'b0001, 1'b0);
    add(4'b0011, 1'b1, 4'b0010, 1'b0);
    // Holder drops req: grant stays until done, then idle.
    add(4'b0000, 1'b0, 4'b0010, 1'b0);
    add(4'b0000, 1'b1, 4'b0000, 1'b0);
    // Released holder still requesting alone: idle one cycle, then regrant.
    add(4'b0100, 1'b0, 4'b0100, 1'b0);
    add(4'b0100, 1'b1, 4'b0000, 1'b0);
    add(4'b0100, 1'b0, 4'b0100, 1'b0);
    add(4'b0000, 1'b1, 4'b0000, 1'b0);

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("reset gnt",       32'(gnt),       32'h0);
    check("reset gnt_valid", 32'(gnt_valid), 32'h0);
    check("reset gnt_idx",   32'(gnt_idx),   32'h0);
    check("reset timeout",   32'(timeout),   32'h0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      step($sformatf("v%0d", i), vecs[i].req, vecs[i].done, vecs[i].gnt, vecs[i].to);
    end

    // Reset mid-grant: grant drops without a clock edge, pointer restarts at 0.
    step("rst_pre", 4'b0011, 1'b0, 4'b0001, 1'b0);
    #2;
    rst  = 1'b1;
    req  = 4'b0000;
    done = 1'b0;
    #1;
    check("async_rst gnt",       32'(gnt),       32'h0);
    check("async_rst gnt_valid", 32'(gnt_valid), 32'h0);
    check("async_rst gnt_idx",   32'(gnt_idx),   32'h0);
    @(negedge clk);
    rst = 1'b0;
    step("rst_post", 4'b1010, 1'b0, 4'b0010, 1'b0);
    step("rst_req3", 4'b1000, 1'b1, 4'b1000, 1'b0);
    step("rst_idle", 4'b0000, 1'b1, 4'b0000, 1'b0);

    // Lone requester overstays: forced release to IDLE, then regranted.
    step("solo_gnt", 4'b0010, 1'b0, 4'b0010, 1'b0);
    for (int k = 0; k < MAX_HOLD - 1; k++) begin
      step($sformatf("solo_hold%0d", k), 4'b0010, 1'b0, 4'b0010, 1'b0);
    end
    step("solo_force", 4'b0010, 1'b0, 4'b0000, 1'b1);
    step("solo_regnt", 4'b0010, 1'b0, 4'b0010, 1'b0);
    step("solo_end",   4'b0000, 1'b1, 4'b0000, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_rr_arbiter

// File: doc/rr_arbiter.md
RR_ARBITER -- requirements
Module: rr_arbiter

Interface
REQ-001 SHALL have parameter N, default 8, meaning number of requesters (N >= 2).
REQ-002 SHALL have parameter MAX_HOLD, default 16, meaning maximum grant duration in cycles before a forced release (MAX_HOLD >= 1).
REQ-003 SHALL have port clk  input  1  rising-edge clock, the only clock.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port req  input  N  request vector; bit i is requester i.
REQ-006 SHALL have port done  input  1  pulse from the shared resource meaning the current holder is finished.
REQ-007 SHALL have port gnt  output  N  registered one-hot grant, or all-zero.
REQ-008 SHALL have port gnt_valid  output  1  high when gnt is non-zero.
REQ-009 SHALL have port gnt_idx  output  $clog2(N)  binary index of the granted bit, and 0 when gnt_valid is low.
REQ-010 SHALL have port timeout  output  1  one-cycle pulse on a forced release.

Function
REQ-011 SHALL implement the two states IDLE (no grant) and BUSY (grant held).
REQ-012 In IDLE with req non-zero at edge t, SHALL enter BUSY and drive the selected one-hot gnt from t+1, giving 1-cycle latency.
REQ-013 Selection SHALL use the masked set req & {bits >= ptr}; if that set is non-zero, the lowest set bit wins, else the lowest set bit of req wins (wrap-around).
REQ-014 Lowest-set-bit isolation SHALL be p & ~(p << 1), where p is the LSB-first prefix OR of the candidate vector.
REQ-015 In BUSY, gnt SHALL stay constant until release, regardless of req changes, including the holder dropping its req.
REQ-016 Release SHALL occur at the edge where done is high, or where hold_cnt reaches MAX_HOLD-1.
REQ-017 On release, ptr SHALL become (granted index + 1) mod N.
REQ-018 On release, if req excluding the released holder is non-zero, SHALL re-arbitrate in the same edge using the updated ptr, with a back-to-back grant and no idle cycle; otherwise SHALL return to IDLE.
REQ-019 The released holder SHALL be eligible again only when it is the sole requester.
REQ-020 hold_cnt SHALL clear on every new grant and increment each BUSY cycle without done; its width SHALL be $clog2(MAX_HOLD+1).
REQ-021 When done and the hold limit coincide, SHALL treat the release as a normal done release with timeout low.
REQ-022 timeout SHALL pulse high for exactly the one cycle following a forced release.
REQ-023 done while in IDLE SHALL be ignored.
REQ-024 gnt, gnt_valid and gnt_idx SHALL all be registered outputs.

Reset
REQ-025 rst high SHALL immediately force state=IDLE, gnt=0, gnt_valid=0, gnt_idx=0, timeout=0, ptr=0 and hold_cnt=0.
REQ-026 Reset asserted mid-grant SHALL drop the grant asynchronously, and the first arbitration after reset deassertion SHALL start from ptr=0.

Structure
REQ-027 A shared package SHALL hold the state enum (IDLE, BUSY) and the index-width helper constant.
REQ-028 The one natural sub-module SHALL be lowest_one, built on the existing prefix_or, which isolates the lowest set bit of an N-bit vector; rr_arbiter SHALL instantiate it twice (masked and unmasked).
REQ-029 One-hot-to-index conversion SHALL be an inline OR-reduction, not a separate module.

Verification (N=4, MAX_HOLD=4)
REQ-030 After reset, req=4'b1010 -> next cycle gnt=4'b0010, gnt_idx=1; done -> next cycle gnt=4'b1000, gnt_idx=3.
REQ-031 req=4'b1111 held constant with done every cycle -> grants rotate 0,1,2,3,0 with no gap cycles.
REQ-032 gnt=4'b1000 then done with req=4'b0011 -> wrap-around to gnt=4'b0001.
REQ-033 Grant held with done never asserted -> forced release after 4 BUSY cycles, timeout=1 for one cycle, next requester granted.
REQ-034 rst pulsed during BUSY -> gnt=0 asynchronously; after deassertion with req=4'b1000, gnt=4'b1000.
REQ-035 Holder drops req while in BUSY -> gnt unchanged until done; done with req=0 -> IDLE, gnt_valid=0.
